mult_div_unit: RTL
==================

# mult_div_unit

Iterative HI/LO multiply/divide unit sitting beside the execute stage of the pipelined core. It consumes the bypassed rs/rt operands of MULT/MULTU/DIV/DIVU when execute issues them, computes over multiple cycles, and owns the architectural HI and LO registers. Execute reads HI/LO for MFHI/MFLO and writes them for MTHI/MTLO. Execute stalls on `busy`.

## Interface
- WIDTH, 32, operand and HI/LO width; the only supported value is 32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  issue a multiply/divide; sampled only in IDLE.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- rs_val  in  WIDTH  multiplicand or dividend, already bypassed by execute.
- rt_val  in  WIDTH  multiplier or divisor, already bypassed by execute.
- hi_in  in  1  MTHI write strobe.
- lo_in  in  1  MTLO write strobe.
- wr_data  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in flight; execute must stall MFHI/MFLO/start.
- done  out  1  one-cycle pulse when HI/LO take a result.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

## Operation
- Reset value (rst=0, asynchronous):
  - state=IDLE, busy=0, done=0, hi=0, lo=0.
  - Internal accumulators and the counter clear.
- IDLE:
  - start=1 latches the operands and op. For signed ops the operands are latched as magnitudes, with the result sign and remainder sign recorded.
  - Load counter=31 and go to CALC.
  - hi_in/lo_in in the same cycle as start: the write is applied and start is still accepted.
- CALC, one iteration per cycle, 32 cycles:
  - Multiply: radix-2 shift-add on a 64-bit {acc,mplier}; unsigned arithmetic on the magnitudes.
  - Divide: restoring division on a 33-bit partial remainder; the quotient is shifted in LSB-first from the dividend.
  - Leave CALC when counter==0.
- FIXUP, 1 cycle:
  - Apply signs. The product is negated if signs differ. The quotient is negated if signs differ. The remainder takes the dividend's sign.
  - Write {hi,lo}: product → hi=upper, lo=lower; divide → lo=quotient, hi=remainder.
  - Pulse done and return to IDLE.
- Divide by zero (no trap):
  - DIVU: lo=0xFFFFFFFF, hi=rs_val.
  - DIV: raw restoring result, then sign fixup with the divisor treated as positive. Example: -7/0 → lo=0x00000001, hi=0xFFFFFFF9.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- hi_in/lo_in while busy:
  - The write takes effect and the in-flight operation is aborted.
  - State returns to IDLE, no done pulse, and the other register is unchanged.
- start while busy is ignored; execute holds it under stall anyway.
- busy is a pure state decode (state!=IDLE), not registered separately.

## Timing
- start accepted at edge N:
  - busy=1 from N+1.
  - CALC occupies edges N+1..N+32.
  - FIXUP edge N+33 writes hi/lo; done=1 during the cycle after N+33, and busy=0 in that same cycle.
- Total latency is 33 cycles from accepting start to HI/LO valid.
- A new start may be accepted in the cycle done is high: back-to-back issue with zero bubble.
- hi/lo change only at the FIXUP edge or on an MTHI/MTLO edge. They are stable for reads at all other times.
- hi_in and lo_in in the same cycle both write wr_data.
- Asynchronous reset mid-CALC forces IDLE immediately and clears hi/lo. No done pulse is emitted.

## Structure
- Shared package `md_pkg`:
  - `md_op_t` enum with values MULT/MULTU/DIV/DIVU.
  - `md_state_t` enum with states IDLE/CALC/FIXUP.
  - `MD_ITER=32`.
  - `MD_DIV0_Q=32'hFFFFFFFF`.
- The package is imported by this block and by execute, which decodes `op`.
- One sub-module, `md_divstep`: combinational single restoring-division step (33-bit subtract, select, quotient bit).
  - Its output feeds the CALC registers.
  - The multiply step stays inline.

## Test plan
- Reset, then MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- MULT -3×7 (0xFFFFFFFD, 7) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTLO 0x1234 issued at CALC cycle 10 of a MULT:
  - Expect lo=0x1234, hi unchanged, busy=0 on the next cycle, and no done pulse.
- Back-to-back: second start issued in the done cycle is accepted; rst=0 asserted mid-CALC → busy=0, hi=lo=0 immediately, no done.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and constants for the HI/LO multiply/divide unit.
package md_pkg;
  typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} md_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} md_state_t;
  localparam int MD_ITER = 32;
  localparam logic [31:0] MD_DIV0_Q = 32'hFFFFFFFF;
endpackage

// File: rtl/md_divstep.sv
// md_divstep: one restoring-division step on a 33-bit partial remainder.
module md_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] trial, diff;
  // trial < 2*d whenever rem < d, so diff's top bit is a clean borrow flag
  always_comb begin
    trial  = {rem[WIDTH-1:0], q_msb};
    diff   = trial - {1'b0, d};
    q_bit  = ~diff[WIDTH];
    rem_nx = q_bit ? diff : trial;
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle shift-add multiply / restoring divide owning HI and LO.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_t          state;
  logic [4:0]         cnt;
  logic [WIDTH:0]     acc, mul_sum, rem_nx;
  logic [WIDTH-1:0]   qr, opb, rs_mag, rt_mag, quo_f, rem_f;
  logic [2*WIDTH-1:0] prod_f;
  logic               is_div, neg_res, neg_rem, rs_neg, rt_neg, q_bit, wr;

  md_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem(acc), .q_msb(qr[WIDTH-1]), .d(opb), .rem_nx(rem_nx), .q_bit(q_bit)
  );

  // acc doubles as product high half and partial remainder; qr as multiplier/dividend/quotient
  always_comb begin
    wr      = hi_in | lo_in;
    rs_neg  = ~op[0] & rs_val[WIDTH-1];
    rt_neg  = ~op[0] & rt_val[WIDTH-1];
    rs_mag  = rs_neg ? -rs_val : rs_val;
    rt_mag  = rt_neg ? -rt_val : rt_val;
    mul_sum = {1'b0, acc[WIDTH-1:0]} + (qr[0] ? {1'b0, opb} : '0);
    prod_f  = neg_res ? -{acc[WIDTH-1:0], qr} : {acc[WIDTH-1:0], qr};
    quo_f   = neg_res ? -qr : qr;
    rem_f   = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    busy    = state != IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      qr      <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (hi_in) hi <= wr_data;
      if (lo_in) lo <= wr_data;
      if (busy && wr) begin
        state <= IDLE;
      end else if (state == IDLE && start) begin
        acc     <= '0;
        qr      <= rs_mag;
        opb     <= rt_mag;
        is_div  <= op[1];
        neg_res <= rs_neg ^ rt_neg;
        neg_rem <= rs_neg;
        cnt     <= 5'(MD_ITER - 1);
        state   <= CALC;
      end else if (state == CALC) begin
        acc   <= is_div ? rem_nx : {1'b0, mul_sum[WIDTH:1]};
        qr    <= is_div ? {qr[WIDTH-2:0], q_bit} : {mul_sum[0], qr[WIDTH-1:1]};
        cnt   <= cnt - 5'd1;
        state <= cnt == 5'd0 ? FIXUP : CALC;
      end else if (state == FIXUP) begin
        hi    <= is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];
        lo    <= is_div ? quo_f : prod_f[WIDTH-1:0];
        done  <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule
